// File: rtl/aes_usb_pkg.sv
// Shared types and constants for the AES <-> USB byte datapath.
package aes_usb_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} insert_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/insert_fifo.sv
// Block-to-byte serializer: takes one AES block from the core and pushes it
// into the output byte FIFO one byte per cycle, byte 0 (LSBs) first, holding
// whenever the FIFO reports full.
module insert_fifo
  import aes_usb_pkg::*;
#(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        load,
  input  logic [BYTE_W*BLOCK_BYTES-1:0] block_in,
  input  logic                        full,
  output logic                        ready,
  output logic                        push,
  output logic [BYTE_W-1:0]           data_out,
  output logic                        done
);

  localparam int BLOCK_W = BYTE_W * BLOCK_BYTES;
  localparam int CNT_W   = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);

  insert_state_t      state, state_next;
  logic [BLOCK_W-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  // State register plus the shift register and byte counter it steers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and datapath update; a full FIFO freezes everything in SEND.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (load) begin
          shreg_next = block_in;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (!full) begin
          shreg_next = shreg >> BYTE_W;
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode; push is Mealy on full so a stalled cycle never writes.
  always_comb begin
    ready    = 1'b0;
    push     = 1'b0;
    done     = 1'b0;
    data_out = shreg[BYTE_W-1:0];
    case (state)
      IDLE:    ready = 1'b1;
      SEND:    push  = ~full;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_insert_fifo.sv
// Directed testbench for insert_fifo: reset, unstalled and stalled blocks,
// loads while busy, back-to-back blocks and reset in the middle of a block.
module tb_insert_fifo;

  logic         clk;
  logic         n_rst;
  logic         load;
  logic [127:0] block_in;
  logic         full;
  logic         ready;
  logic         push;
  logic [7:0]   data_out;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] BLK_B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] BLK_C = 128'h3C3B3A39383736353433323130_2F2E2D;
  localparam logic [127:0] BLK_AA = {16{8'hAA}};

  insert_fifo #(.BLOCK_BYTES(16)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load),
    .block_in (block_in),
    .full     (full),
    .ready    (ready),
    .push     (push),
    .data_out (data_out),
    .done     (done)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ld, input logic [127:0] blk, input logic fl);
    load     = ld;
    block_in = blk;
    full     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic exp_ready, input logic exp_push,
                             input logic exp_done, input logic [7:0] exp_data, input bit chk_data);
    checks++;
    assert (ready === exp_ready) else begin
      errors++;
      $error("[TB] FAIL %s ready observed %b expected %b", tag, ready, exp_ready);
    end
    checks++;
    assert (push === exp_push) else begin
      errors++;
      $error("[TB] FAIL %s push observed %b expected %b", tag, push, exp_push);
    end
    checks++;
    assert (done === exp_done) else begin
      errors++;
      $error("[TB] FAIL %s done observed %b expected %b", tag, done, exp_done);
    end
    if (chk_data) begin
      checks++;
      assert (data_out === exp_data) else begin
        errors++;
        $error("[TB] FAIL %s data_out observed %h expected %h", tag, data_out, exp_data);
      end
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    checks++;
    assert (observed == expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called in an idle cycle just after a rising edge: loads blk at the next
  // edge (edge 0), then checks cycles 1..exp_done. Stalls cover cycles
  // stall_lo..stall_hi plus stall_last. busy1/busy2 pulse an 0xAA load in
  // those cycles. Returns just after the edge that ends the done cycle.
  task automatic runBlock(input string tag, input logic [127:0] blk,
                          input int stall_lo, input int stall_hi, input int stall_last,
                          input int busy1, input int busy2, input int exp_done);
    int  nb;
    logic stall;
    nb = 0;
    applyStimulus(1'b1, blk, 1'b0);
    @(negedge clk);
    checkOutput({tag, " idle"}, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, ~blk, 1'b0);
    for (int c = 1; c <= exp_done; c++) begin
      stall = ((c >= stall_lo) && (c <= stall_hi)) || (c == stall_last);
      if ((c == busy1) || (c == busy2)) applyStimulus(1'b1, BLK_AA, stall);
      else                              applyStimulus(1'b0, ~blk, stall);
      @(negedge clk);
      if (c == exp_done) begin
        checkOutput({tag, " done"}, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkCount({tag, " bytes"}, nb, 16);
      end else begin
        checkOutput($sformatf("%s c%0d", tag, c), 1'b0, !stall, 1'b0,
                    blk[8*nb +: 8], !stall);
        if (!stall) nb++;
      end
      @(posedge clk); #1;
      applyStimulus(1'b0, ~blk, 1'b0);
    end
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b0);
    n_rst = 1'b1;

    // Asynchronous reset asserted mid-cycle takes effect at once.
    #2 n_rst = 1'b0;
    #1 checkOutput("reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    @(posedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Unstalled block: bytes in cycles 1..16, done in 17, ready in 18.
    runBlock("plain", BLK_A, 0, -1, 0, 0, 0, 17);
    @(negedge clk);
    checkOutput("plain ready", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;

    // Backpressure in cycles 3-5 and on the last byte: done moves to 21.
    runBlock("stall", BLK_A, 3, 5, 19, 0, 0, 21);

    // Loads during SEND and DONE are ignored.
    runBlock("busy", BLK_A, 0, -1, 0, 5, 17, 17);
    @(negedge clk);
    checkOutput("busy ready", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busy still idle", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;

    // Back-to-back: block B loaded at A's edge 18.
    runBlock("b2b A", BLK_A, 0, -1, 0, 0, 0, 17);
    runBlock("b2b B", BLK_B, 0, -1, 0, 0, 0, 17);

    // Reset after 7 pushes abandons the block without a done pulse.
    applyStimulus(1'b1, BLK_B, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("pre-reset c%0d", c), 1'b0, 1'b1, 1'b0, BLK_B[8*(c-1) +: 8], 1'b1);
      @(posedge clk); #1;
    end
    #1 n_rst = 1'b0;
    #1 checkOutput("mid reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    runBlock("after reset", BLK_C, 0, -1, 0, 0, 0, 17);
    @(negedge clk);
    checkOutput("final ready", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
